// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//   NUM_CH independent PWM channels that share one programmable period counter
//   and one clock prescaler. DUTY, PERIOD and PRESCALE writes go to shadow
//   registers. The shadow values are copied into the active registers only at a
//   period boundary or on sync_load, so the outputs never glitch.
//
//   Optional build macro: PWM_CENTER_ALIGN_EN
//     Defined  : the counter runs as a triangle (0..P..0). Reload and
//                period_tick happen at the bottom turnaround.
//     Undefined: the counter is edge-aligned (0..P, then wraps to 0).
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   wr_en        register write strobe
//   wr_addr      0..NUM_CH-1 = DUTY[i], NUM_CH = PERIOD, NUM_CH+1 = PRESCALE
//   wr_data      write data
//   sync_load    load shadow->active now and restart the counters
//   en_out       per-channel output enable
//   en_pwm       per-channel PWM enable (0 = static high when enabled)
//   out          registered channel outputs
//   period_tick  one-cycle pulse, the cycle after each period boundary
//   cnt_val      current period counter
// -----------------------------------------------------------------------------

// Per-channel slice: duty shadow/active pair and the registered output.
module pwm_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_data,
  input  logic             i_ld_sync,
  input  logic             i_ld_wrap,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_en_out,
  input  logic             i_en_pwm,
  output logic             o_out
);
  logic [CNT_W-1:0] r_duty_sh, r_duty_act, w_duty_sh_nxt;

  // A write in the same cycle as sync_load bypasses into the active value.
  assign w_duty_sh_nxt = i_wr ? i_wr_data : r_duty_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_sh  <= '0;
      r_duty_act <= '0;
      o_out      <= 1'b0;
    end else begin
      r_duty_sh <= w_duty_sh_nxt;
      // A wrap loads the pre-edge shadow. A write on that edge waits for the next wrap.
      if (i_ld_sync)      r_duty_act <= w_duty_sh_nxt;
      else if (i_ld_wrap) r_duty_act <= r_duty_sh;
      // Count and active duty change on the same edge, so the comparison
      // always uses a matched pair. DUTY=0 or DUTY>PERIOD therefore never glitches.
      o_out <= i_en_out & (~i_en_pwm | (i_cnt < r_duty_act));
    end
  end
endmodule

module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic              sync_load,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  output logic [NUM_CH-1:0] out,
  output logic              period_tick,
  output logic [CNT_W-1:0]  cnt_val
);
  localparam logic [ADDR_W-1:0] A_PER = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] A_PSC = ADDR_W'(NUM_CH + 1);

  logic [CNT_W-1:0]  r_per_sh, r_per_act, r_psc_sh, r_psc_act;
  logic [CNT_W-1:0]  r_psc_cnt, r_cnt;
  logic [CNT_W-1:0]  w_per_sh_nxt, w_psc_sh_nxt, w_cnt_nxt;
  logic              w_tick, w_wrap;
  logic [NUM_CH-1:0] w_wr_ch;

  assign w_per_sh_nxt = (wr_en && wr_addr == A_PER) ? wr_data : r_per_sh;
  assign w_psc_sh_nxt = (wr_en && wr_addr == A_PSC) ? wr_data : r_psc_sh;

  assign w_tick  = (r_psc_cnt == r_psc_act);
  // A period ends on the tick whose next count is 0. Both counting modes use this rule.
  assign w_wrap  = w_tick && (w_cnt_nxt == '0);
  assign cnt_val = r_cnt;

`ifdef PWM_CENTER_ALIGN_EN
  logic r_dir_up, w_dir_nxt;

  always_comb begin
    w_dir_nxt = r_dir_up;
    w_cnt_nxt = r_cnt;
    if (r_dir_up) begin
      if (r_cnt >= r_per_act) begin
        // At the top, turn around. PERIOD=0 holds the counter at 0.
        w_cnt_nxt = (r_per_act == '0) ? '0 : r_per_act - CNT_W'(1);
        w_dir_nxt = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
    if (w_cnt_nxt == '0) w_dir_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_dir_up <= 1'b1;
    else if (sync_load) r_dir_up <= 1'b1;
    else if (w_tick)    r_dir_up <= w_dir_nxt;
  end
`else
  assign w_cnt_nxt = (r_cnt == r_per_act) ? '0 : r_cnt + CNT_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_sh    <= '1;
      r_per_act   <= '1;
      r_psc_sh    <= '0;
      r_psc_act   <= '0;
      r_psc_cnt   <= '0;
      r_cnt       <= '0;
      period_tick <= 1'b0;
    end else begin
      r_per_sh    <= w_per_sh_nxt;
      r_psc_sh    <= w_psc_sh_nxt;
      period_tick <= w_wrap && !sync_load;
      if (sync_load) begin
        r_per_act <= w_per_sh_nxt;
        r_psc_act <= w_psc_sh_nxt;
        r_psc_cnt <= '0;
        r_cnt     <= '0;
      end else begin
        r_psc_cnt <= w_tick ? '0 : r_psc_cnt + CNT_W'(1);
        if (w_tick) r_cnt <= w_cnt_nxt;
        // New PERIOD/PRESCALE apply only when the count restarts at 0.
        // A smaller PERIOD therefore cannot strand the counter above it.
        if (w_wrap) begin
          r_per_act <= r_per_sh;
          r_psc_act <= r_psc_sh;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_ch[g] = wr_en && (wr_addr == ADDR_W'(g));

    pwm_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr_ch[g]),
      .i_wr_data (wr_data),
      .i_ld_sync (sync_load),
      .i_ld_wrap (w_wrap),
      .i_cnt     (r_cnt),
      .i_en_out  (en_out[g]),
      .i_en_pwm  (en_pwm[g]),
      .o_out     (out[g])
    );
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;
  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;
  logic              sync_load;
  logic [NUM_CH-1:0] en_out, en_pwm, out;
  logic              period_tick;
  logic [CNT_W-1:0]  cnt_val;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sync_load(sync_load), .en_out(en_out), .en_pwm(en_pwm), .out(out),
    .period_tick(period_tick), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. Position in the period is tracked as elapsed clk cycles
  // since the period start. The count value is that time divided by the
  // prescale factor. A period lasts (P+1)*(S+1) cycles.
  int               m_sh_duty[NUM_CH], m_duty[NUM_CH];
  int               m_sh_per, m_per, m_sh_psc, m_psc, m_t;
  logic [NUM_CH-1:0] m_out;
  logic             m_ptick;

  always @(posedge clk or posedge rst) begin
    int cur, len, osd[NUM_CH], osp, oss;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin m_sh_duty[i] = 0; m_duty[i] = 0; end
      m_sh_per = 255; m_per = 255; m_sh_psc = 0; m_psc = 0; m_t = 0;
      m_out = '0; m_ptick = 1'b0;
    end else begin
      cur = m_t / (m_psc + 1);
      len = (m_per + 1) * (m_psc + 1);
      for (int i = 0; i < NUM_CH; i++)
        m_out[i] = en_out[i] ? (en_pwm[i] ? (cur < m_duty[i]) : 1'b1) : 1'b0;
      for (int i = 0; i < NUM_CH; i++) osd[i] = m_sh_duty[i];
      osp = m_sh_per; oss = m_sh_psc;
      if (wr_en) begin
        if (int'(wr_addr) < NUM_CH)       m_sh_duty[int'(wr_addr)] = int'(wr_data);
        else if (int'(wr_addr) == NUM_CH) m_sh_per = int'(wr_data);
        else if (int'(wr_addr) == NUM_CH+1) m_sh_psc = int'(wr_data);
      end
      m_ptick = 1'b0;
      if (sync_load) begin
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_sh_duty[i];
        m_per = m_sh_per; m_psc = m_sh_psc; m_t = 0;
      end else if (m_t == len - 1) begin
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = osd[i];
        m_per = osp; m_psc = oss; m_t = 0; m_ptick = 1'b1;
      end else begin
        m_t++;
      end
    end
  end

  // Compare process: checks every cycle against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out", 32'(out), 32'(m_out));
      check("period_tick", 32'(period_tick), 32'(m_ptick));
      check("cnt_val", 32'(cnt_val), 32'(m_t / (m_psc + 1)));
    end
  end

  task automatic wr(int a, int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = CNT_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic sync();
    @(negedge clk); sync_load = 1'b1;
    @(negedge clk); sync_load = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for period_tick, at most lim cycles. Returns the number of cycles waited.
  task automatic wait_ptick(int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_tick && n < lim);
  endtask

  logic [19:0] exp_o3, exp_pt;
  int n, gap, hi;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; sync_load = 1'b0;
    en_out = '0; en_pwm = '0;
    #23;
    check("rst_out", 32'(out), 0);
    check("rst_ptick", 32'(period_tick), 0);
    check("rst_cnt", 32'(cnt_val), 0);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;

    // Basic duty: PERIOD=9, DUTY[3]=4 -> 4 high, 6 low; tick every 10.
    en_out = 16'h0008; en_pwm = 16'h0008;
    wr(3, 4); wr(NUM_CH, 9); wr(NUM_CH + 1, 0); sync();
    exp_o3 = 20'b0000001111_0000001111;
    exp_pt = 20'b1000000000_1000000000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("basic_out3", 32'(out[3]), 32'(exp_o3[k]));
      check("basic_ptick", 32'(period_tick), 32'(exp_pt[k]));
    end

    // Shadow timing: DUTY[0]=2 active, write 7 mid-period.
    en_out[0] = 1'b1; en_pwm[0] = 1'b1;
    wr(0, 2); sync();
    n = 0;
    while (cnt_val != 8'd5 && n < 50) begin @(negedge clk); n++; end
    check("wait_cnt5", 32'(n < 50), 1);
    wr(0, 7);
    wait_ptick(40, n);
    check("wait_ptick_shadow", 32'(period_tick), 1);
    hi = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); hi += int'(out[0]); end
    check("shadow_high_cnt", 32'(hi), 7);

    // Extremes and enables.
    wr(1, 0); wr(2, 10);
    en_out = 16'h0017; en_pwm = 16'h0027;
    sync();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("duty0_low", 32'(out[1]), 0);
      check("duty_gt_per_high", 32'(out[2]), 1);
      check("static_high", 32'(out[4]), 1);
      check("en_out_off", 32'(out[5]), 0);
    end

    // Prescaler: PRESCALE=3, PERIOD=4 -> 20 cycles per period.
    wr(NUM_CH, 4); wr(NUM_CH + 1, 3); sync();
    wait_ptick(100, n);
    check("psc_first", 32'(n), 20);
    wr(NUM_CH + 2, 1);
    wr(63, 0);
    wait_ptick(100, n);
    wait_ptick(100, gap);
    check("psc_gap_after_bad_addr", 32'(gap), 20);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 63))
                                            : ADDR_W'($urandom_range(0, NUM_CH + 1));
      if (int'(wr_addr) == NUM_CH)          wr_data = CNT_W'($urandom_range(0, 12));
      else if (int'(wr_addr) == NUM_CH + 1) wr_data = CNT_W'($urandom_range(0, 3));
      else if ($urandom_range(0, 15) == 0)  wr_data = CNT_W'($urandom_range(0, 255));
      else                                  wr_data = CNT_W'($urandom_range(0, 14));
      sync_load = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        en_out = NUM_CH'($urandom);
        en_pwm = NUM_CH'($urandom);
      end
    end
    @(negedge clk); wr_en = 1'b0; sync_load = 1'b0;

    // Async reset mid-run with outputs driven high.
    en_out = '1; en_pwm = '0;
    idle(3);
    check("pre_rst_out_high", 32'(out), 32'hFFFF);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 0);
    check("async_rst_ptick", 32'(period_tick), 0);
    check("async_rst_cnt", 32'(cnt_val), 0);
    @(negedge clk); rst = 1'b0; en_pwm = '1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_duty0", 32'(out), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised successor to the single-duty PWM peripheral. It provides NUM_CH independent PWM channels, each with its own duty register, plus a programmable period and clock prescaler. Duty, period and prescaler writes are double-buffered and take effect only at a period boundary, so outputs never glitch. It sits behind the SPI register peripheral, which drives the write port and the per-channel enable vectors; out feeds the chip's output pins.

Parameters:
NUM_CH, 16, number of PWM channels (1..32)
CNT_W, 8, width of period counter, duty, period and prescaler registers
ADDR_W, 6, write-address width; must satisfy 2^ADDR_W >= NUM_CH+2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  register write strobe, one write per cycle
wr_addr  input  ADDR_W  0..NUM_CH-1 = DUTY[i]; NUM_CH = PERIOD; NUM_CH+1 = PRESCALE
wr_data  input  CNT_W  write data
sync_load  input  1  pulse: force immediate shadow->active load and counter restart
en_out  input  NUM_CH  per-channel output enable
en_pwm  input  NUM_CH  per-channel PWM enable (0 = static high when en_out=1)
out  output  NUM_CH  registered channel outputs
period_tick  output  1  one-cycle pulse marking start of each period
cnt_val  output  CNT_W  current period counter, for debug/observability

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. Asserting rst clears all state immediately, independent of clk.
- Reset values:
  - shadow and active DUTY = 0; PERIOD = 2^CNT_W-1; PRESCALE = 0
  - psc_cnt = 0, cnt = 0, out = 0, period_tick = 0, cnt_val = 0
- Writes:
  - On a clk edge with wr_en=1, the shadow register selected by wr_addr takes wr_data.
  - Addresses >= NUM_CH+2 are ignored; no state changes.
- Prescaler:
  - psc_cnt counts 0..PRESCALE_act, then wraps to 0.
  - tick is asserted on the cycle where psc_cnt == PRESCALE_act. PRESCALE_act=0 gives a tick every cycle.
- Period counter (edge-aligned):
  - On each tick, cnt increments; when cnt == PERIOD_act, it wraps to 0.
  - Period length = (PERIOD_act+1)*(PRESCALE_act+1) clk cycles.
- Shadow update:
  - On the edge where cnt wraps to 0, all active registers load from the shadow values held before that edge.
  - A write landing on the same edge takes effect at the following wrap.
- period_tick: registered; high for exactly one clk cycle, the cycle after each wrap edge.
- Channel output, registered (1 clk latency from cnt):
  - pwm_i = (cnt < DUTY_act[i])
  - out[i] = en_out[i] ? (en_pwm[i] ? pwm_i : 1) : 0
  - DUTY=0 gives constant low; DUTY > PERIOD_act gives constant high (100%). No single-cycle glitch at either extreme.
- sync_load:
  - Next edge copies shadow to active and clears cnt and psc_cnt to 0. It does not pulse period_tick.
  - Takes precedence over a coincident wrap.
  - If wr_en coincides, the written value is included in the load (write bypasses into active).
- Changing PERIOD below the current cnt cannot strand the counter: new values only apply at cnt=0.
- Enables are not buffered; they affect out on the next clk edge.
- cnt_val = cnt, combinational from the register.

Optional Feature:
Macro PWM_CENTER_ALIGN_EN.
- Defined:
  - cnt counts up 0..PERIOD_act, then down PERIOD_act..0 (triangle), one step per tick. Period = 2*PERIOD_act ticks; PERIOD_act=0 holds cnt at 0.
  - pwm_i = (cnt < DUTY_act[i]), giving symmetric pulses.
  - Shadow update and period_tick occur only at the bottom turnaround (down-count reaching 0). sync_load restarts counting up from 0.
- Undefined: edge-aligned behaviour only; no direction register synthesised.

Test Plan:
- Reset defaults: assert rst mid-run with out active -> out=0, period_tick=0 and cnt_val=0 immediately; after release with DUTY=0 all outputs stay 0.
- Basic duty: NUM_CH=16, PERIOD=9, PRESCALE=0, DUTY[3]=4, en_out[3]=en_pwm[3]=1, sync_load -> out[3] high 4 cycles, low 6, repeating; period_tick every 10 cycles.
- Shadow timing: running PERIOD=9, DUTY[0]=2; write DUTY[0]=7 at cnt=5 -> rest of current period still 2-high; next period 7-high, switching exactly at the period_tick boundary.
- Extremes and enables:
  - DUTY[1]=0 -> out[1] constantly 0.
  - DUTY[2]=10 with PERIOD=9 -> out[2] constantly 1.
  - en_pwm[4]=0, en_out[4]=1 -> out[4]=1.
  - en_out[5]=0 -> out[5]=0.
- Prescaler/address: PRESCALE=3, PERIOD=4 -> period_tick every 20 clk cycles; write to addr NUM_CH+2 -> no register changes.
- Center-aligned (macro defined): PERIOD=4, DUTY[0]=2 -> cnt sequence 0,1,2,3,4,3,2,1,0...; out[0] high on cnt 0,1 in both directions; period_tick every 8 ticks.
